// File: rtl/debounce_multi.sv
// N-channel debouncer: per-channel stability counter, registered level and rise/fall strobes.
// Optional DEBOUNCE_MULTI_SYNC_EN adds a 2-flop input synchroniser per channel.

module debounce_multi_lane #(
    parameter int               CNT_W = 16,
    parameter logic [CNT_W-1:0] LAST  = '0,
    parameter logic             INIT  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic samp,
    output logic level,
    output logic rise,
    output logic fall,
    output logic accept
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             differ;

    assign differ = (samp != level);
    assign accept = differ && (cnt == LAST);

    // A sample matching the current level throws away the whole window.
    always_comb begin
        cnt_nxt = '0;
        if (differ && !accept)
            cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level <= INIT;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            rise <= accept & samp;
            fall <= accept & ~samp;
            if (accept)
                level <= samp;
        end
    end
endmodule

module debounce_multi #(
    parameter int                NUM_CH       = 4,
    parameter int                CNT_W        = 16,
    parameter longint            STABLE_COUNT = 65535,
    parameter logic [NUM_CH-1:0] INIT_LEVEL   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] data_in,
    output logic [NUM_CH-1:0] data_debounced,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic              any_change
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_COUNT - 1);

    if (STABLE_COUNT < 1 || STABLE_COUNT > (longint'(1) << CNT_W)) begin : g_bad_count
        $error("debounce_multi: STABLE_COUNT must be in 1..2**CNT_W");
    end

    logic [NUM_CH-1:0] samp;
    logic [NUM_CH-1:0] accept;

`ifdef DEBOUNCE_MULTI_SYNC_EN
    logic [NUM_CH-1:0] sync_q1;
    logic [NUM_CH-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= INIT_LEVEL;
            sync_q2 <= INIT_LEVEL;
        end else begin
            sync_q1 <= data_in;
            sync_q2 <= sync_q1;
        end
    end

    assign samp = sync_q2;
`else
    assign samp = data_in;
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
        debounce_multi_lane #(
            .CNT_W (CNT_W),
            .LAST  (LAST),
            .INIT  (INIT_LEVEL[ch])
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .samp   (samp[ch]),
            .level  (data_debounced[ch]),
            .rise   (rise_pulse[ch]),
            .fall   (fall_pulse[ch]),
            .accept (accept[ch])
        );
    end

    // Registered from the same accept terms as the strobes so it lines up with them.
    always_ff @(posedge clk) begin
        if (reset)
            any_change <= 1'b0;
        else
            any_change <= |accept;
    end
endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: SC=4 instance (INIT 0101) and SC=1 instance (INIT 0000),
// checked against a sliding-window model through a scoreboard queue.

module tb_debounce_multi;
    logic       clk;
    logic       reset;
    logic [3:0] data_a, data_b;
    logic [3:0] lvl_a, rise_a, fall_a, lvl_b, rise_b, fall_b;
    logic       any_a, any_b;

    debounce_multi #(.NUM_CH(4), .CNT_W(16), .STABLE_COUNT(4), .INIT_LEVEL(4'b0101)) dut_a (
        .clk(clk), .reset(reset), .data_in(data_a), .data_debounced(lvl_a),
        .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a));

    debounce_multi #(.NUM_CH(4), .CNT_W(4), .STABLE_COUNT(1), .INIT_LEVEL(4'b0000)) dut_b (
        .clk(clk), .reset(reset), .data_in(data_b), .data_debounced(lvl_b),
        .rise_pulse(rise_b), .fall_pulse(fall_b), .any_change(any_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } out_t;

    typedef struct {
        out_t a;
        out_t b;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: a channel flips once its last SC samples since reset all differ from its level.
    int          m_sc[2]   = '{4, 1};
    logic [3:0]  m_init[2] = '{4'b0101, 4'b0000};
    logic [3:0]  m_lvl[2];
    logic [31:0] m_hist[2][4];
    int          m_nv[2][4];
    logic [3:0]  m_s1[2], m_s2[2];

    task automatic model(input int m, input logic [3:0] din, input bit rst, output out_t o);
        logic [3:0] s;
        bit all_diff;
        o.rise = '0;
        o.fall = '0;
`ifdef DEBOUNCE_MULTI_SYNC_EN
        s = m_s2[m];
        m_s2[m] = m_s1[m];
        m_s1[m] = din;
`else
        s = din;
`endif
        if (rst) begin
            m_lvl[m] = m_init[m];
            m_s1[m]  = m_init[m];
            m_s2[m]  = m_init[m];
            for (int c = 0; c < 4; c++) begin
                m_hist[m][c] = '0;
                m_nv[m][c]   = 0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                m_hist[m][c] = {m_hist[m][c][30:0], s[c]};
                m_nv[m][c]++;
                all_diff = (m_nv[m][c] >= m_sc[m]);
                for (int k = 0; k < m_sc[m]; k++)
                    if (m_hist[m][c][k] == m_lvl[m][c]) all_diff = 0;
                if (all_diff) begin
                    m_lvl[m][c] = s[c];
                    if (s[c]) o.rise[c] = 1'b1;
                    else      o.fall[c] = 1'b1;
                end
            end
        end
        o.lvl = m_lvl[m];
        o.any = |(o.rise | o.fall);
    endtask

    int cyc = 0;

    task automatic drive(input logic [3:0] a, input bit rst);
        exp_t e;
        logic [3:0] b;
        @(negedge clk);
        b = {3'($urandom_range(0, 7)), 1'((cyc / 2) % 2)};
        cyc++;
        data_a = a;
        data_b = b;
        reset  = rst;
        model(0, a, rst, e.a);
        model(1, b, rst, e.b);
        sb.push_back(e);
    endtask

    task automatic hold(input logic [3:0] a, input int n);
        for (int i = 0; i < n; i++) drive(a, 1'b0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("a.level", 32'(lvl_a),  32'(e.a.lvl));
            chk("a.rise",  32'(rise_a), 32'(e.a.rise));
            chk("a.fall",  32'(fall_a), 32'(e.a.fall));
            chk("a.any",   32'(any_a),  32'(e.a.any));
            chk("b.level", 32'(lvl_b),  32'(e.b.lvl));
            chk("b.rise",  32'(rise_b), 32'(e.b.rise));
            chk("b.fall",  32'(fall_b), 32'(e.b.fall));
            chk("b.any",   32'(any_b),  32'(e.b.any));
        end
    end

    initial begin
        logic [3:0] r;
        reset  = 1'b1;
        data_a = 4'b0101;
        data_b = 4'b0000;
        for (int i = 0; i < 3; i++) drive(4'b0101, 1'b1);
        hold(4'b0101, 3);
        // clean steps on ch0: fall then rise
        hold(4'b0100, 6);
        hold(4'b0101, 6);
        // bounce on ch1 against level 0, then a clean hold
        for (int rep = 0; rep < 3; rep++) begin
            hold(4'b0111, 3);
            hold(4'b0101, 1);
        end
        hold(4'b0111, 5);
        // ch2 1->0 and ch3 0->1 together
        hold(4'b1011, 6);
        // reset in the middle of a count
        hold(4'b1010, 3);
        drive(4'b1010, 1'b1);
        hold(4'b1010, 6);
        // random levels with bounces, occasional reset
        for (int i = 0; i < 25; i++) begin
            r = 4'($urandom_range(0, 15));
            hold(r, $urandom_range(1, 6));
            if ($urandom_range(0, 19) == 0) drive(r, 1'b1);
        end
        hold(r, 6);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel debouncer; successor to the single-channel 16-bit fixed-threshold debouncer.
- Per channel: saturating-free stability counter, configurable threshold, and configurable reset level.
- Adds registered rise/fall strobes and an aggregate change flag.
- Sits between board pins (buttons, switches) and control logic.

Parameters:
- NUM_CH, 4, number of independent channels (>=1).
- CNT_W, 16, width of each per-channel stability counter.
- STABLE_COUNT, 65535, consecutive differing samples needed to accept a new level; legal range 1..2^CNT_W.
- INIT_LEVEL, 0, NUM_CH-bit vector: debounced level of each channel after reset.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  NUM_CH  raw, possibly bouncing inputs.
- data_debounced  output  NUM_CH  accepted stable level per channel (registered).
- rise_pulse  output  NUM_CH  one-cycle strobe: channel accepted 0->1.
- fall_pulse  output  NUM_CH  one-cycle strobe: channel accepted 1->0.
- any_change  output  1  OR of all rise_pulse and fall_pulse bits (registered, same cycle).

Behaviour:
- Reset (reset=1 at posedge):
  - data_debounced <= INIT_LEVEL.
  - All counters <= 0.
  - rise_pulse, fall_pulse, any_change <= 0.
  - Synchroniser flops (if present) <= INIT_LEVEL.
  - Reset overrides all other activity, including a count in progress; there is no partial credit after reset.
- Sample s[i] = data_in[i], or the synchroniser output when SYNC is enabled.
- Per channel, at each posedge with reset=0:
  - s==data_debounced: cnt <= 0; no pulse.
  - s!=data_debounced and cnt < STABLE_COUNT-1: cnt <= cnt+1; no pulse.
  - s!=data_debounced and cnt == STABLE_COUNT-1: data_debounced <= s; cnt <= 0; rise_pulse (s=1) or fall_pulse (s=0) <= 1 for exactly this one cycle.
- Any single sample equal to the current level clears the count. Bounces therefore restart the window; there is no hysteresis accumulation.
- Latency: with SYNC disabled, data_debounced changes on the STABLE_COUNT-th posedge that samples the new level, i.e. exactly STABLE_COUNT cycles after the first differing sample.
- STABLE_COUNT=1: the output follows the input one cycle later; every accepted transition produces a pulse.
- Counter arithmetic is CNT_W unsigned. It never wraps, because it is cleared at STABLE_COUNT-1. An elaboration-time error is required if STABLE_COUNT is 0 or exceeds 2^CNT_W.
- Channels are fully independent. Simultaneous transitions on several channels give simultaneous pulses, and any_change is a single high cycle.
- Back-to-back accepted transitions on one channel are spaced at least STABLE_COUNT cycles apart. Pulses on a channel are therefore never adjacent unless STABLE_COUNT=1.
- rise_pulse[i] and fall_pulse[i] are never high together.

Optional Feature:
- Macro: DEBOUNCE_MULTI_SYNC_EN.
- Defined: each data_in bit passes through a 2-flop synchroniser (reset to INIT_LEVEL) before the counter logic, adding exactly 2 cycles to all latencies.
- Undefined: data_in feeds the counter logic directly. Inputs must then already be synchronous to clk.

Test Plan:
- Reset release (NUM_CH=4, INIT_LEVEL=4'b0101, STABLE_COUNT=4): hold reset 3 cycles, data_in=4'b0101 -> data_debounced=4'b0101, all pulses and any_change 0, throughout and after release.
- Clean step (STABLE_COUNT=4, SYNC off): ch0 0->1 held -> data_debounced[0]=1 and rise_pulse[0]=1 for one cycle, on the 4th posedge after the change. any_change high in the same cycle.
- Bounce reject: ch1 pattern 1,1,1,0,1,1,1,0 repeated against level 0 -> data_debounced[1] stays 0, no pulses. Then hold 1 for 4 cycles -> rise_pulse[1] once.
- Multi-channel simultaneity: ch2 1->0 and ch3 0->1 at the same cycle -> fall_pulse[2] and rise_pulse[3] in the same cycle, any_change a single high cycle.
- Reset mid-count: ch0 differs for 3 of 4 cycles, assert reset 1 cycle, keep input changed -> no transition until 4 further full cycles after release. data_debounced returns to INIT_LEVEL during reset.
- STABLE_COUNT=1, plus DEBOUNCE_MULTI_SYNC_EN defined: toggle data_in[0] every 2 cycles -> data_debounced[0] tracks the input delayed 3 cycles, one pulse per edge, alternating rise/fall.
